// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the FFT frame controller slice.
//   cplx_t     : complex sample {re, im} at the default component width
//   state_e    : frame controller FSM states
//   tw_idx_w() : width of a per-stage twiddle ROM index (LOG2_N - 1)
package fft_pkg;

    localparam int FFT_DATA_WIDTH = 32;

    typedef logic signed [0:1][FFT_DATA_WIDTH-1:0] cplx_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAD   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int tw_idx_w(input int log2n);
        return log2n - 1;
    endfunction

endpackage

// File: rtl/fft_stage_cnt.sv
// fft_stage_cnt: sample counter and twiddle index generator for one FFT stage.
//   clk, rst_n : clock, async active-low reset
//   in_valid   : in_valid of this stage, one count per sample
//   tw_idx     : twiddle ROM index for the sample currently at this stage
module fft_stage_cnt
    import fft_pkg::*;
#(
    parameter  int LOG2_N = 5,
    parameter  int STAGE  = 1,
    localparam int TW_W   = tw_idx_w(LOG2_N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic [TW_W-1:0] tw_idx
);

    // Stage s uses the low s-1 count bits, scaled up to the full ROM range.
    localparam logic [LOG2_N-1:0] MASK  = LOG2_N'((1 << (STAGE - 1)) - 1);
    localparam int                SHIFT = LOG2_N - STAGE;

    logic [LOG2_N-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + LOG2_N'(in_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tw_idx = TW_W'(cnt_q & MASK) << SHIFT;

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame-level controller for a streaming radix-2 FFT chain.
//   s_data/s_valid/s_ready : upstream sample stream
//   flush_req              : pulse; pad the partial frame and push a dummy frame
//   pipe_din/pipe_valid    : registered sample into stage 1
//   stage_valid            : per-stage in_valid taps, drive the twiddle counters
//   tw_idx                 : per-stage twiddle ROM index
//   pipe_out_valid         : last-stage out_valid
//   m_valid/m_first/m_last : last-stage output tags for real frames
//   busy                   : flush in progress
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter  int N           = 32,
    parameter  int DATA_WIDTH  = 32,
    parameter  int FRAME_CNT_W = 4,
    localparam int LOG2_N      = $clog2(N)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [0:1][DATA_WIDTH-1:0]        s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic                              flush_req,
    output logic [0:1][DATA_WIDTH-1:0]        pipe_din,
    output logic                              pipe_valid,
    input  logic [1:LOG2_N]                   stage_valid,
    output logic [1:LOG2_N][LOG2_N-2:0]       tw_idx,
    input  logic                              pipe_out_valid,
    output logic                              m_valid,
    output logic                              m_first,
    output logic                              m_last,
    output logic                              busy
);

    localparam logic [LOG2_N-1:0]      LAST    = LOG2_N'(N - 1);
    localparam logic [FRAME_CNT_W-1:0] FR_FULL = '1;

    state_e                      state_q, state_d;
    logic [LOG2_N-1:0]           in_cnt_q, in_cnt_d;
    logic [LOG2_N-1:0]           out_cnt_q, out_cnt_d;
    logic [LOG2_N-1:0]           drain_cnt_q, drain_cnt_d;
    logic                        drain_done_q, drain_done_d;
    logic [FRAME_CNT_W-1:0]      frames_q, frames_d;
    logic [0:1][DATA_WIDTH-1:0]  pipe_din_q, pipe_din_d;
    logic                        pipe_valid_q, pipe_valid_d;
    logic                        accept;
    logic                        fr_inc;

    assign s_ready = (state_q == ST_RUN) && (frames_q != FR_FULL);
    assign accept  = s_valid && s_ready;
    assign busy    = (state_q != ST_RUN);

    // Outputs are tagged only while a real frame is still owed downstream;
    // out_cnt advances regardless so dummy outputs keep frame alignment.
    assign m_valid = pipe_out_valid && (frames_q != '0);
    assign m_first = m_valid && (out_cnt_q == '0);
    assign m_last  = m_valid && (out_cnt_q == LAST);

    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        drain_done_d = drain_done_q;
        pipe_valid_d = 1'b0;
        pipe_din_d   = pipe_din_q;
        fr_inc       = 1'b0;
        frames_d     = frames_q;
        out_cnt_d    = out_cnt_q + LOG2_N'(pipe_out_valid);

        case (state_q)
            ST_RUN: begin
                drain_cnt_d  = '0;
                drain_done_d = 1'b0;
                if (accept) begin
                    pipe_valid_d = 1'b1;
                    pipe_din_d   = s_data;
                    in_cnt_d     = in_cnt_q + 1'b1;
                    fr_inc       = (in_cnt_q == LAST);
                end
            end
            ST_PAD: begin
                pipe_valid_d = 1'b1;
                pipe_din_d   = '0;
                in_cnt_d     = in_cnt_q + 1'b1;
                if (in_cnt_q == LAST) begin
                    fr_inc  = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!drain_done_q) begin
                    pipe_valid_d = 1'b1;
                    pipe_din_d   = '0;
                    drain_cnt_d  = drain_cnt_q + 1'b1;
                    if (drain_cnt_q == LAST) drain_done_d = 1'b1;
                end else if (frames_q == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Wrap and m_last together cancel out.
        case ({fr_inc, m_last})
            2'b10:   frames_d = frames_q + 1'b1;
            2'b01:   frames_d = frames_q - 1'b1;
            default: frames_d = frames_q;
        endcase

        // Flush decision looks at the counts after this cycle's accept/output,
        // so a sample accepted alongside the pulse is part of the flushed work.
        if ((state_q == ST_RUN) && flush_req) begin
            if (in_cnt_d != '0)      state_d = ST_PAD;
            else if (frames_d != '0) state_d = ST_DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            drain_cnt_q  <= '0;
            drain_done_q <= 1'b0;
            frames_q     <= '0;
            pipe_din_q   <= '0;
            pipe_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            drain_done_q <= drain_done_d;
            frames_q     <= frames_d;
            pipe_din_q   <= pipe_din_d;
            pipe_valid_q <= pipe_valid_d;
        end
    end

    assign pipe_din   = pipe_din_q;
    assign pipe_valid = pipe_valid_q;

    for (genvar s = 1; s <= LOG2_N; s++) begin : g_stage
        fft_stage_cnt #(
            .LOG2_N (LOG2_N),
            .STAGE  (s)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (stage_valid[s]),
            .tw_idx   (tw_idx[s])
        );
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed + random bench for fft_frame_ctrl (N=8, 2-bit
// frame counter). The reference tracks sample/frame counts as integers and
// models a flush as a queue of pending injected samples (pad or dummy).
module tb_fft_frame_ctrl;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int FW = 2;
    localparam int L  = 3;
    localparam int FR_MAX = (1 << FW) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [0:1][DW-1:0]     s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic                   flush_req;
    logic [0:1][DW-1:0]     pipe_din;
    logic                   pipe_valid;
    logic [1:L]             stage_valid;
    logic [1:L][L-2:0]      tw_idx;
    logic                   pipe_out_valid;
    logic                   m_valid, m_first, m_last;
    logic                   busy;

    fft_frame_ctrl #(.N(N), .DATA_WIDTH(DW), .FRAME_CNT_W(FW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .flush_req      (flush_req),
        .pipe_din       (pipe_din),
        .pipe_valid     (pipe_valid),
        .stage_valid    (stage_valid),
        .tw_idx         (tw_idx),
        .pipe_out_valid (pipe_out_valid),
        .m_valid        (m_valid),
        .m_first        (m_first),
        .m_last         (m_last),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // reference state
    int          m_in, m_fr, m_out;
    int          m_sc [1:L];
    int          inj [$];        // 1 = pad sample (counts toward frame), 0 = dummy
    bit          m_wait;         // dummy frame sent, waiting for real frames to leave
    bit          e_pv;
    logic [31:0] e_din;
    bit          e_mlast;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy();
        return (inj.size() != 0) || m_wait;
    endfunction

    task automatic m_reset();
        m_in = 0; m_fr = 0; m_out = 0;
        for (int s = 1; s <= L; s++) m_sc[s] = 0;
        inj.delete();
        m_wait = 1'b0; e_pv = 1'b0; e_din = '0; e_mlast = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_s_ready",    32'(s_ready),    32'd1);
        chk("rst_pipe_valid", 32'(pipe_valid), 32'd0);
        chk("rst_pipe_din",   32'(pipe_din),   32'd0);
        chk("rst_tw_idx",     32'(tw_idx),     32'd0);
        chk("rst_m_valid",    32'(m_valid),    32'd0);
        chk("rst_m_first",    32'(m_first),    32'd0);
        chk("rst_m_last",     32'(m_last),     32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
    endtask

    task automatic check_comb();
        bit rdy, mv, mf;
        rdy     = !m_busy() && (m_fr != FR_MAX);
        mv      = pipe_out_valid && (m_fr != 0);
        mf      = mv && (m_out == 0);
        e_mlast = mv && (m_out == N - 1);
        chk("s_ready", 32'(s_ready), 32'(rdy));
        chk("m_valid", 32'(m_valid), 32'(mv));
        chk("m_first", 32'(m_first), 32'(mf));
        chk("m_last",  32'(m_last),  32'(e_mlast));
        for (int s = 1; s <= L; s++)
            chk($sformatf("tw_idx[%0d]", s), 32'(tw_idx[s]),
                (m_sc[s] % (1 << (s - 1))) * (1 << (L - s)));
    endtask

    task automatic model_edge();
        int inc, dec, e;
        inc = 0;
        dec = e_mlast ? 1 : 0;
        if (!m_busy()) begin
            if (s_valid && (m_fr != FR_MAX)) begin
                e_pv  = 1'b1;
                e_din = s_data;
                if (m_in == N - 1) inc = 1;
                m_in = (m_in + 1) % N;
            end else begin
                e_pv = 1'b0;
            end
            if (flush_req) begin
                if (m_in != 0) begin
                    repeat (N - m_in) inj.push_back(1);
                    repeat (N) inj.push_back(0);
                end else if (m_fr + inc - dec != 0) begin
                    repeat (N) inj.push_back(0);
                end
            end
        end else if (inj.size() != 0) begin
            e     = inj.pop_front();
            e_pv  = 1'b1;
            e_din = '0;
            if (e == 1) begin
                if (m_in == N - 1) inc = 1;
                m_in = (m_in + 1) % N;
            end
            if (inj.size() == 0) m_wait = 1'b1;
        end else begin
            e_pv = 1'b0;
            if (m_fr == 0) m_wait = 1'b0;
        end
        m_fr += inc - dec;
        for (int s = 1; s <= L; s++) m_sc[s] = (m_sc[s] + int'(stage_valid[s])) % N;
        m_out = (m_out + int'(pipe_out_valid)) % N;
    endtask

    task automatic check_reg();
        chk("pipe_valid", 32'(pipe_valid), 32'(e_pv));
        chk("busy",       32'(busy),       32'(m_busy()));
        if (e_pv) chk("pipe_din", 32'(pipe_din), e_din);
    endtask

    // one clock: combinational checks before the edge, registered after
    task automatic cyc();
        #1;
        check_comb();
        @(posedge clk);
        model_edge();
        #1;
        check_reg();
    endtask

    task automatic idle();
        s_valid = 1'b0; flush_req = 1'b0; stage_valid = '0; pipe_out_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_pv, cnt_mf, cnt_ml, cnt_mv;
        idle();
        s_data = '0;
        rst_n  = 1'b0;
        #12;
        check_reset_vals();
        m_reset();
        @(negedge clk) rst_n = 1'b1;

        // one full frame of samples 1..8
        cnt_pv = 0;
        for (int i = 1; i <= N; i++) begin
            s_valid = 1'b1;
            s_data  = {DW'(i), DW'($urandom)};
            cyc();
            cnt_pv += int'(pipe_valid);
        end
        idle();
        cyc();
        chk("frame1_pipe_valid_cycles", 32'(cnt_pv), 32'd8);

        // stage counters 2 and 3 stepped together
        for (int i = 0; i < N; i++) begin
            stage_valid = 3'b011;
            cyc();
        end
        idle();

        // frame 1 leaves the chain
        cnt_mf = 0; cnt_ml = 0;
        for (int i = 0; i < N; i++) begin
            pipe_out_valid = 1'b1;
            #1;
            cnt_mf += int'(m_first); cnt_ml += int'(m_last);
            cyc();
        end
        idle();
        chk("frame1_m_first_cnt", 32'(cnt_mf), 32'd1);
        chk("frame1_m_last_cnt",  32'(cnt_ml), 32'd1);

        // partial frame of 3, then flush: 5 pad + 8 dummy
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = {DW'($urandom), DW'($urandom)};
            cyc();
        end
        idle();
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        cnt_pv = 0; cnt_mf = 0; cnt_ml = 0; cnt_mv = 0;
        for (int k = 0; k < 30; k++) begin
            pipe_out_valid = (k >= 5 && k < 21);
            stage_valid    = 3'(pipe_out_valid ? 3'b111 : 3'b000);
            #1;
            cnt_mf += int'(m_first); cnt_ml += int'(m_last); cnt_mv += int'(m_valid);
            cyc();
            cnt_pv += int'(pipe_valid);
        end
        idle();
        chk("flush_inject_cnt", 32'(cnt_pv), 32'd13);
        chk("flush_m_valid_cnt", 32'(cnt_mv), 32'd8);
        chk("flush_m_first_cnt", 32'(cnt_mf), 32'd1);
        chk("flush_m_last_cnt",  32'(cnt_ml), 32'd1);
        chk("flush_busy_end", 32'(busy), 32'd0);

        // fill three frames with no output: backpressure
        for (int i = 0; i < 3 * N; i++) begin
            s_valid = 1'b1;
            s_data  = {DW'($urandom), DW'($urandom)};
            cyc();
        end
        #1;
        chk("full_s_ready", 32'(s_ready), 32'd0);
        cyc();
        idle();
        for (int i = 0; i < N; i++) begin
            pipe_out_valid = 1'b1;
            cyc();
        end
        idle();
        #1;
        chk("after_m_last_s_ready", 32'(s_ready), 32'd1);

        // input wrap coincides with m_last
        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1; pipe_out_valid = 1'b1;
            s_data  = {DW'($urandom), DW'($urandom)};
            cyc();
        end
        idle();
        cnt_mv = 0;
        for (int i = 0; i < 2 * N + 1; i++) begin
            pipe_out_valid = 1'b1;
            #1;
            cnt_mv += int'(m_valid);
            cyc();
        end
        idle();
        chk("wrap_and_last_m_valid_cnt", 32'(cnt_mv), 32'd16);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            s_valid        = 1'($urandom);
            s_data         = {DW'($urandom), DW'($urandom)};
            pipe_out_valid = ($urandom_range(0, 2) == 0);
            stage_valid    = 3'($urandom);
            flush_req      = ($urandom_range(0, 39) == 0);
            cyc();
        end
        idle();
        for (int i = 0; i < 40; i++) begin
            pipe_out_valid = 1'b1;
            cyc();
        end
        idle();
        cyc();
        chk("random_end_busy", 32'(busy), 32'd0);

        // reset while draining
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = {DW'($urandom), DW'($urandom)};
            cyc();
        end
        idle();
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        m_reset();
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < N; i++) begin
            s_valid = 1'b1;
            s_data  = {DW'($urandom), DW'($urandom)};
            cyc();
        end
        idle();
        cnt_mf = 0; cnt_mv = 0;
        for (int i = 0; i < N + 2; i++) begin
            pipe_out_valid = 1'b1;
            #1;
            cnt_mf += int'(m_first); cnt_mv += int'(m_valid);
            cyc();
        end
        idle();
        chk("post_reset_m_first_cnt", 32'(cnt_mf), 32'd1);
        chk("post_reset_m_valid_cnt", 32'(cnt_mv), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
